// File: rtl/nlp_predictor_pkg.sv
// Shared definitions for the next-line predictor.
// Holds the saturating-counter encodings, the FSM state type and the
// entry, nlpInfo and NLPUpdate payload layouts used across the fetch pipe.
package nlp_predictor_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned BIM_W        = 2;
    localparam int unsigned NLP_TAG_BITS = 8;

    // Bimodal counter encodings: strongly/weakly not-taken, weakly/strongly taken.
    localparam logic [BIM_W-1:0] SN = 2'b00;
    localparam logic [BIM_W-1:0] WN = 2'b01;
    localparam logic [BIM_W-1:0] WT = 2'b10;
    localparam logic [BIM_W-1:0] ST = 2'b11;

    typedef enum logic [0:0] {
        NLP_IDLE  = 1'b0,
        NLP_SWEEP = 1'b1
    } nlp_state_e;

    // One table entry at the default tag width.
    typedef struct packed {
        logic                    valid;
        logic [NLP_TAG_BITS-1:0] tag;
        logic [XLEN-1:0]         target;
        logic [BIM_W-1:0]        bimState;
    } NLPEntry;

    // Per-slot prediction that travels down the fetch pipeline.
    typedef struct packed {
        logic             valid;
        logic             taken;
        logic [XLEN-1:0]  target;
        logic [BIM_W-1:0] bimState;
    } NLPInfo;

    // Training request coming back from IF3.
    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  target;
        logic [BIM_W-1:0] bimState;
        logic             shouldTake;
    } NLPUpdateReq;

endpackage

// File: rtl/nlp_bim_counter.sv
// Combinational 2-bit saturating counter step.
// Ports:
//   state      - counter value observed by IF3
//   take       - final branch decision (1 = count up, 0 = count down)
//   bim_next_c - stepped value, saturating at SN and ST
module nlp_bim_counter
    import nlp_predictor_pkg::*;
(
    input  logic [BIM_W-1:0] state,
    input  logic             take,
    output logic [BIM_W-1:0] bim_next_c
);

    always_comb begin
        bim_next_c = state;
        case (state)
            SN:      bim_next_c = take ? WN : SN;
            WN:      bim_next_c = take ? WT : SN;
            WT:      bim_next_c = take ? ST : WN;
            default: bim_next_c = take ? ST : WT;
        endcase
    end

endmodule

// File: rtl/nlp_predictor.sv
// Next-line predictor: direct-mapped BTB with a 2-bit bimodal counter per entry.
// Optional macro NLP_BYPASS_EN: forward a same-edge update to a lookup at the
// same index; when undefined such a lookup sees the pre-update table.
// Ports:
//   clk, rst                 - clock (rising edge), async active-low reset
//   lookupValid, lookupPC    - IF1 fetch group; slot1 is lookupPC+4
//   stall                    - hold the registered lookup outputs
//   nlpValid/Taken/Target/BimState{0,1} - registered per-slot prediction
//   updValid, updPC, updTarget, updBimState, updShouldTake - IF3 training
//   invalidate               - pulse that starts a full-table clear sweep
//   busy                     - sweep in progress
module nlp_predictor
    import nlp_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned TAG_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lookupValid,
    input  logic [XLEN-1:0]      lookupPC,
    input  logic                 stall,
    output logic                 nlpValid0,
    output logic                 nlpValid1,
    output logic                 nlpTaken0,
    output logic                 nlpTaken1,
    output logic [XLEN-1:0]      nlpTarget0,
    output logic [XLEN-1:0]      nlpTarget1,
    output logic [BIM_W-1:0]     nlpBimState0,
    output logic [BIM_W-1:0]     nlpBimState1,
    input  logic                 updValid,
    input  logic [XLEN-1:0]      updPC,
    input  logic [XLEN-1:0]      updTarget,
    input  logic [BIM_W-1:0]     updBimState,
    input  logic                 updShouldTake,
    input  logic                 invalidate,
    output logic                 busy
);

    localparam int unsigned IDX    = $clog2(ENTRIES);
    localparam int unsigned IDX_HI = IDX + 1;
    localparam int unsigned TAG_LO = IDX + 2;
    localparam int unsigned TAG_HI = IDX + 1 + TAG_BITS;

    nlp_state_e          state_q, state_d;
    logic [IDX-1:0]      ctr_q, ctr_d;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [BIM_W-1:0]    bim_q    [ENTRIES];

    NLPUpdateReq         upd;
    logic                upd_fire;
    logic [IDX-1:0]      uidx;
    logic [TAG_BITS-1:0] utag;
    logic [BIM_W-1:0]    ubim;

    logic [XLEN-1:0]     pc1;
    logic [IDX-1:0]      idx0, idx1;
    logic [TAG_BITS-1:0] tag0, tag1;
    NLPInfo              info0_c, info1_c, info0_q, info1_q;
    logic                unused_bits;

    assign upd = '{valid: updValid, pc: updPC, target: updTarget,
                   bimState: updBimState, shouldTake: updShouldTake};

    // Updates are only accepted while the table is not being swept.
    assign upd_fire = upd.valid && (state_q == NLP_IDLE);
    assign uidx     = upd.pc[IDX_HI:2];
    assign utag     = upd.pc[TAG_HI:TAG_LO];

    nlp_bim_counter u_bim (
        .state      (upd.bimState),
        .take       (upd.shouldTake),
        .bim_next_c (ubim)
    );

    assign pc1  = lookupPC + XLEN'(4);
    assign idx0 = lookupPC[IDX_HI:2];
    assign tag0 = lookupPC[TAG_HI:TAG_LO];
    assign idx1 = pc1[IDX_HI:2];
    assign tag1 = pc1[TAG_HI:TAG_LO];

    // PC bits outside the index/tag window carry no prediction state.
    assign unused_bits = ^{lookupPC, pc1, upd};

    // One read port; misses return an all-zero nlpInfo.
    function automatic NLPInfo lookup_slot(input logic [IDX-1:0]      idx,
                                           input logic [TAG_BITS-1:0] tag);
        logic                e_valid;
        logic [TAG_BITS-1:0] e_tag;
        logic [XLEN-1:0]     e_target;
        logic [BIM_W-1:0]    e_bim;
        NLPInfo              info;
        e_valid  = valid_q[idx];
        e_tag    = tag_q[idx];
        e_target = target_q[idx];
        e_bim    = bim_q[idx];
`ifdef NLP_BYPASS_EN
        // The entry being written this edge replaces the stored one.
        if (upd_fire && (idx == uidx)) begin
            e_valid  = 1'b1;
            e_tag    = utag;
            e_target = upd.target;
            e_bim    = ubim;
        end
`endif
        info = '0;
        if (lookupValid && !busy && e_valid && (e_tag == tag)) begin
            info.valid    = 1'b1;
            info.taken    = e_bim[1];
            info.target   = e_target;
            info.bimState = e_bim;
        end
        return info;
    endfunction

    assign info0_c = lookup_slot(idx0, tag0);
    assign info1_c = lookup_slot(idx1, tag1);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= NLP_IDLE;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    end

    // FSM next state; a new invalidate restarts the sweep from entry 0.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        case (state_q)
            NLP_IDLE: begin
                if (invalidate) begin
                    state_d = NLP_SWEEP;
                    ctr_d   = '0;
                end
            end
            NLP_SWEEP: begin
                if (invalidate) begin
                    ctr_d = '0;
                end else if (ctr_q == '1) begin
                    state_d = NLP_IDLE;
                    ctr_d   = '0;
                end else begin
                    ctr_d = ctr_q + IDX'(1);
                end
            end
            default: begin
                state_d = NLP_IDLE;
                ctr_d   = '0;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = 1'b0;
        if (state_q == NLP_SWEEP) begin
            busy = 1'b1;
        end
    end

    // Valid bits and lookup output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            info0_q <= '0;
            info1_q <= '0;
        end else begin
            if (upd_fire) begin
                valid_q[uidx] <= 1'b1;
            end
            if (busy) begin
                valid_q[ctr_q] <= 1'b0;
            end
            if (!stall) begin
                info0_q <= info0_c;
                info1_q <= info1_c;
            end
        end
    end

    // Entry payload; gated by the valid bits so it needs no reset.
    always_ff @(posedge clk) begin
        if (upd_fire) begin
            tag_q[uidx]    <= utag;
            target_q[uidx] <= upd.target;
            bim_q[uidx]    <= ubim;
        end
    end

    assign nlpValid0    = info0_q.valid;
    assign nlpTaken0    = info0_q.taken;
    assign nlpTarget0   = info0_q.target;
    assign nlpBimState0 = info0_q.bimState;
    assign nlpValid1    = info1_q.valid;
    assign nlpTaken1    = info1_q.taken;
    assign nlpTarget1   = info1_q.target;
    assign nlpBimState1 = info1_q.bimState;

endmodule

// File: tb/tb_nlp_predictor.sv
// Self-checking bench for nlp_predictor: a table-level behavioural model is
// compared with the DUT on every cycle, plus directed literal expectations.
module tb_nlp_predictor;

    localparam int unsigned ENTRIES  = 64;
    localparam int unsigned TAG_BITS = 8;
    localparam int unsigned IDX      = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        lookupValid;
    logic [31:0] lookupPC;
    logic        stall;
    logic        nlpValid0, nlpValid1, nlpTaken0, nlpTaken1;
    logic [31:0] nlpTarget0, nlpTarget1;
    logic [1:0]  nlpBimState0, nlpBimState1;
    logic        updValid;
    logic [31:0] updPC;
    logic [31:0] updTarget;
    logic [1:0]  updBimState;
    logic        updShouldTake;
    logic        invalidate;
    logic        busy;

    always #5 clk = ~clk;

    nlp_predictor #(.ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .lookupValid  (lookupValid),
        .lookupPC     (lookupPC),
        .stall        (stall),
        .nlpValid0    (nlpValid0),
        .nlpValid1    (nlpValid1),
        .nlpTaken0    (nlpTaken0),
        .nlpTaken1    (nlpTaken1),
        .nlpTarget0   (nlpTarget0),
        .nlpTarget1   (nlpTarget1),
        .nlpBimState0 (nlpBimState0),
        .nlpBimState1 (nlpBimState1),
        .updValid     (updValid),
        .updPC        (updPC),
        .updTarget    (updTarget),
        .updBimState  (updBimState),
        .updShouldTake(updShouldTake),
        .invalidate   (invalidate),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;
    bit compare_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid [ENTRIES];
    int          m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_bim   [ENTRIES];
    int          m_sweep_left;
    bit          e_valid [2];
    bit          e_taken [2];
    logic [31:0] e_tgt   [2];
    int          e_bim   [2];

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> (2 + IDX)) % (32'd1 << TAG_BITS));
    endfunction

    function automatic int sat(input int b, input bit up);
        if (up) return (b == 3) ? 3 : b + 1;
        return (b == 0) ? 0 : b - 1;
    endfunction

    always @(posedge clk or negedge rst) begin
        bit          busy_now, upd_ok, v, hit;
        int          i, t, b;
        logic [31:0] pc, tg;
        if (!rst) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
            m_sweep_left = 0;
            for (int s = 0; s < 2; s++) begin
                e_valid[s] = 1'b0; e_taken[s] = 1'b0; e_tgt[s] = 32'd0; e_bim[s] = 0;
            end
        end else begin
            busy_now = (m_sweep_left > 0);
            upd_ok   = updValid && !busy_now;
            if (!stall) begin
                for (int s = 0; s < 2; s++) begin
                    pc = lookupPC + 32'(4 * s);
                    i  = idx_of(pc);
                    v  = m_valid[i]; t = m_tag[i]; tg = m_tgt[i]; b = m_bim[i];
`ifdef NLP_BYPASS_EN
                    if (upd_ok && idx_of(updPC) == i) begin
                        v = 1'b1; t = tag_of(updPC); tg = updTarget;
                        b = sat(int'(updBimState), updShouldTake);
                    end
`endif
                    hit = lookupValid && !busy_now && v && (t == tag_of(pc));
                    e_valid[s] = hit;
                    e_taken[s] = hit && (b >= 2);
                    e_tgt[s]   = hit ? tg : 32'd0;
                    e_bim[s]   = hit ? b : 0;
                end
            end
            if (upd_ok) begin
                i = idx_of(updPC);
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(updPC);
                m_tgt[i]   = updTarget;
                m_bim[i]   = sat(int'(updBimState), updShouldTake);
            end
            // The sweep is modelled as an immediate clear plus a busy window.
            if (invalidate) begin
                for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
                m_sweep_left = ENTRIES;
            end else if (busy_now) begin
                m_sweep_left--;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (compare_en) begin
            chk("cyc_valid0",  32'(nlpValid0),    32'(e_valid[0]));
            chk("cyc_taken0",  32'(nlpTaken0),    32'(e_taken[0]));
            chk("cyc_target0", nlpTarget0,        e_tgt[0]);
            chk("cyc_bim0",    32'(nlpBimState0), 32'(e_bim[0]));
            chk("cyc_valid1",  32'(nlpValid1),    32'(e_valid[1]));
            chk("cyc_taken1",  32'(nlpTaken1),    32'(e_taken[1]));
            chk("cyc_target1", nlpTarget1,        e_tgt[1]);
            chk("cyc_bim1",    32'(nlpBimState1), 32'(e_bim[1]));
            chk("cyc_busy",    32'(busy),         32'(m_sweep_left > 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt,
                             input logic [1:0] bim, input logic take);
        updValid = 1'b1; updPC = pc; updTarget = tgt;
        updBimState = bim; updShouldTake = take;
        tick();
        updValid = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] pc);
        lookupValid = 1'b1; lookupPC = pc;
        tick();
        lookupValid = 1'b0;
    endtask

    task automatic populate();
        do_update(32'hBFC0_0080, 32'hBFC0_1080, 2'b10, 1'b1);
        do_update(32'hBFC0_0084, 32'hBFC0_1084, 2'b10, 1'b1);
        do_update(32'hBFC0_0088, 32'hBFC0_1088, 2'b01, 1'b0);
        do_update(32'hBFC0_008C, 32'hBFC0_108C, 2'b01, 1'b1);
    endtask

    logic [1:0] up_bim [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    logic [1:0] dn_bim [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
    int n;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        lookupValid = 1'b0; lookupPC = 32'd0; stall = 1'b0;
        updValid = 1'b0; updPC = 32'd0; updTarget = 32'd0;
        updBimState = 2'b00; updShouldTake = 1'b0; invalidate = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        compare_en = 1'b1;
        chk("reset_valid0", 32'(nlpValid0), 32'd0);
        chk("reset_target0", nlpTarget0, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        #1 rst = 1'b1;
        @(negedge clk);

        // Cold lookup misses.
        do_lookup(32'hBFC0_0010);
        chk("cold_valid0", 32'(nlpValid0), 32'd0);
        chk("cold_taken0", 32'(nlpTaken0), 32'd0);
        chk("cold_target0", nlpTarget0, 32'd0);

        // Train then hit; bim 01 stepped up to 10.
        do_update(32'hBFC0_0010, 32'hBFC0_0100, 2'b01, 1'b1);
        do_lookup(32'hBFC0_0010);
        chk("hit_valid0", 32'(nlpValid0), 32'd1);
        chk("hit_bim0", 32'(nlpBimState0), 32'd2);
        chk("hit_taken0", 32'(nlpTaken0), 32'd1);
        chk("hit_target0", nlpTarget0, 32'hBFC0_0100);
        chk("hit_slot1_miss", 32'(nlpValid1), 32'd0);

        // Alias at index 4 with tag 0x01 evicts the first entry.
        do_update(32'hBFC0_0110, 32'hBFC0_0200, 2'b01, 1'b0);
        do_lookup(32'hBFC0_0010);
        chk("alias_old_miss", 32'(nlpValid0), 32'd0);
        do_lookup(32'hBFC0_0110);
        chk("alias_new_valid", 32'(nlpValid0), 32'd1);
        chk("alias_new_taken", 32'(nlpTaken0), 32'd0);
        chk("alias_new_target", nlpTarget0, 32'hBFC0_0200);

        // Saturation upward then downward.
        for (int k = 0; k < 4; k++) do_update(32'hBFC0_0020, 32'hBFC0_0300, up_bim[k], 1'b1);
        do_lookup(32'hBFC0_0020);
        chk("sat_hi_bim", 32'(nlpBimState0), 32'd3);
        for (int k = 0; k < 4; k++) do_update(32'hBFC0_0020, 32'hBFC0_0300, dn_bim[k], 1'b0);
        do_lookup(32'hBFC0_0020);
        chk("sat_lo_bim", 32'(nlpBimState0), 32'd0);
        chk("sat_lo_valid", 32'(nlpValid0), 32'd1);
        chk("sat_lo_taken", 32'(nlpTaken0), 32'd0);

        // Same-edge update and lookup at one index.
        updValid = 1'b1; updPC = 32'hBFC0_0040; updTarget = 32'hBFC0_0400;
        updBimState = 2'b01; updShouldTake = 1'b1;
        lookupValid = 1'b1; lookupPC = 32'hBFC0_0040;
        tick();
        updValid = 1'b0; lookupValid = 1'b0;
`ifdef NLP_BYPASS_EN
        chk("same_edge_valid", 32'(nlpValid0), 32'd1);
        chk("same_edge_target", nlpTarget0, 32'hBFC0_0400);
`else
        chk("same_edge_valid", 32'(nlpValid0), 32'd0);
        chk("same_edge_target", nlpTarget0, 32'd0);
`endif
        do_lookup(32'hBFC0_0040);
        chk("after_same_edge_valid", 32'(nlpValid0), 32'd1);

        // Invalidate sweep; an update mid-sweep is dropped.
        populate();
        do_lookup(32'hBFC0_0080);
        chk("pop_valid0", 32'(nlpValid0), 32'd1);
        chk("pop_valid1", 32'(nlpValid1), 32'd1);
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        updPC = 32'hBFC0_0090; updTarget = 32'hBFC0_1090;
        updBimState = 2'b10; updShouldTake = 1'b1;
        lookupValid = 1'b1; lookupPC = 32'hBFC0_0080;
        n = 0;
        while (busy && n < 200) begin
            n++;
            updValid = (n == 5);
            tick();
        end
        updValid = 1'b0; lookupValid = 1'b0;
        chk("sweep_len", 32'(n), 32'd64);
        do_lookup(32'hBFC0_0080);
        chk("post_sweep_80", 32'(nlpValid0), 32'd0);
        chk("post_sweep_84", 32'(nlpValid1), 32'd0);
        do_lookup(32'hBFC0_0088);
        chk("post_sweep_88", 32'(nlpValid0), 32'd0);
        do_lookup(32'hBFC0_0090);
        chk("dropped_update", 32'(nlpValid0), 32'd0);

        // Second pulse ten cycles in restarts the sweep.
        populate();
        invalidate = 1'b1;
        tick();
        n = 0;
        while (busy && n < 200) begin
            n++;
            invalidate = (n == 10);
            tick();
        end
        invalidate = 1'b0;
        chk("restart_len", 32'(n), 32'd74);

        // Reset in the middle of a sweep.
        populate();
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #1 rst = 1'b0;
        #1 chk("mid_sweep_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        do_lookup(32'hBFC0_0080);
        chk("after_rst_80", 32'(nlpValid0), 32'd0);
        do_lookup(32'hBFC0_008C);
        chk("after_rst_8c", 32'(nlpValid0), 32'd0);

        // Stall holds outputs while lookupPC moves.
        do_update(32'hBFC0_00C0, 32'hBFC0_0C00, 2'b10, 1'b1);
        lookupValid = 1'b1; lookupPC = 32'hBFC0_00C0;
        tick();
        chk("stall_pre_target", nlpTarget0, 32'hBFC0_0C00);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lookupPC = 32'hBFC0_0010 + 32'(8 * k);
            tick();
            chk("stall_hold_target", nlpTarget0, 32'hBFC0_0C00);
            chk("stall_hold_bim", 32'(nlpBimState0), 32'd3);
        end
        stall = 1'b0;
        tick();
        chk("stall_release_valid", 32'(nlpValid0), 32'd0);
        lookupValid = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
